capsense_scan: RTL

//  N-channel capacitive-touch scanner; successor to the single-bit threshold sampler. Per scan: discharge all pads, release,

---
 rtl/capsense_pkg.sv | 19 +
 rtl/capsense_chan.sv | 98 +++++++++
 rtl/capsense_scan.sv | 131 +++++++++++++
 3 files changed

// File: rtl/capsense_pkg.sv
// Shared types and helpers for the capacitive-touch scanner.
package capsense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISCHARGE,
    ST_CHARGE,
    ST_EVAL
  } cs_state_t;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/capsense_chan.sv
// One scanner channel: charge-time latch, overflow flag and press classification.
// CAPSENSE_BASELINE_EN adds a per-channel IIR baseline in place of the fixed threshold.
module capsense_chan
  import capsense_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PRESS_THRESH = 4
`ifdef CAPSENSE_BASELINE_EN
  ,
  parameter int unsigned BASE_SHIFT   = 3
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             tick,
  input  logic             at_max,
  input  logic             pad,
  input  logic [CNT_W-1:0] cnt,
  input  logic             eval,
  output logic             latched,
  output logic [CNT_W-1:0] count_o,
  output logic             pressed_o,
  output logic             overflow_o
);

  logic [CNT_W-1:0] cnt_lat;
  logic             ovf_lat;
  logic             press_cmp;

  // at_max only matters on the final tick: an unlatched pad takes CNT_MAX and flags overflow
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      latched <= 1'b0;
      cnt_lat <= '0;
      ovf_lat <= 1'b0;
    end else if (tick && !latched) begin
      if (pad) begin
        latched <= 1'b1;
        cnt_lat <= cnt;
      end else if (at_max) begin
        latched <= 1'b1;
        cnt_lat <= cnt;
        ovf_lat <= 1'b1;
      end
    end
  end

`ifdef CAPSENSE_BASELINE_EN
  logic [CNT_W-1:0]        base;
  logic                    first_scan;
  logic signed [CNT_W:0]   diff;
  logic signed [CNT_W:0]   step;

  always_comb begin
    press_cmp = {1'b0, cnt_lat} > ({1'b0, base} + (CNT_W+1)'(PRESS_THRESH));
    diff      = signed'({1'b0, cnt_lat}) - signed'({1'b0, base});
    step      = diff >>> BASE_SHIFT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o    <= '0;
      pressed_o  <= 1'b0;
      overflow_o <= 1'b0;
      base       <= '0;
      first_scan <= 1'b1;
    end else if (eval) begin
      count_o    <= cnt_lat;
      overflow_o <= ovf_lat;
      if (first_scan) begin
        base       <= cnt_lat;
        pressed_o  <= 1'b0;
        first_scan <= 1'b0;
      end else begin
        pressed_o <= press_cmp;
        if (!press_cmp && !ovf_lat)
          base <= base + step[CNT_W-1:0];
      end
    end
  end
`else
  always_comb press_cmp = {1'b0, cnt_lat} > (CNT_W+1)'(PRESS_THRESH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o    <= '0;
      pressed_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else if (eval) begin
      count_o    <= cnt_lat;
      overflow_o <= ovf_lat;
      pressed_o  <= press_cmp;
    end
  end
`endif

endmodule

// File: rtl/capsense_scan.sv
// N-channel capacitive-touch scanner: discharge, release, time each pad's charge, classify.
// Optional CAPSENSE_BASELINE_EN selects per-channel adaptive baseline classification.
module capsense_scan
  import capsense_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DISCHARGE_CYC = 16,
  parameter int unsigned PRESS_THRESH  = 4,
  parameter int unsigned BASE_SHIFT    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ena_i,
  input  logic               start_i,
  input  logic [N-1:0]       buttons_i,
  output logic               buttons_oe,
  output logic               busy_o,
  output logic               done_o,
  output logic [N*CNT_W-1:0] count_o,
  output logic [N-1:0]       pressed_o,
  output logic [N-1:0]       overflow_o
);

  localparam logic [CNT_W-1:0] CMAX     = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYC - 1);

  if (DISCHARGE_CYC < 1 || DISCHARGE_CYC > cnt_max(CNT_W) + 1 || BASE_SHIFT > CNT_W) begin : g_cfg_check
    $error("capsense_scan: invalid parameter set");
  end

  cs_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [N-1:0]     sync1, sync2;
  logic [N-1:0]     latched;
  logic             clear, tick, eval, at_max;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_o <= eval;
    end
  end

  assign at_max = (cnt == CMAX);

  // Exit test uses this tick's pad samples so a final latch and the exit share one tick
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clear    = 1'b0;
    tick     = 1'b0;
    eval     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nx = ST_DISCHARGE;
          cnt_nx   = '0;
        end
      end
      ST_DISCHARGE: begin
        if (ena_i) begin
          if (cnt == DIS_LAST) begin
            state_nx = ST_CHARGE;
            cnt_nx   = '0;
            clear    = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ST_CHARGE: begin
        if (ena_i) begin
          tick = 1'b1;
          if (&(latched | sync2) || at_max)
            state_nx = ST_EVAL;
          else
            cnt_nx = cnt + 1'b1;
        end
      end
      ST_EVAL: begin
        eval     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign buttons_oe = (state != ST_CHARGE);
  assign busy_o     = (state != ST_IDLE);

  for (genvar k = 0; k < N; k++) begin : g_chan
    capsense_chan #(
      .CNT_W        (CNT_W),
      .PRESS_THRESH (PRESS_THRESH)
`ifdef CAPSENSE_BASELINE_EN
      ,
      .BASE_SHIFT   (BASE_SHIFT)
`endif
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (clear),
      .tick       (tick),
      .at_max     (at_max),
      .pad        (sync2[k]),
      .cnt        (cnt),
      .eval       (eval),
      .latched    (latched[k]),
      .count_o    (count_o[chan_lsb(k, CNT_W) +: CNT_W]),
      .pressed_o  (pressed_o[k]),
      .overflow_o (overflow_o[k])
    );
  end

endmodule
